hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Pipeline stall/flush controller that pairs with the operand-forwarding unit.
- The forwarding unit resolves hazards it can bypass. This block stalls or squashes stages for hazards forwarding cannot cover:
  - load-use dependences;
  - data-memory wait states;
  - taken branches resolved in EX.
- Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and drives their write-enable, bubble and flush controls.

Parameters:
- LOAD_LAT, 1, total stall cycles per load-use hazard (1..15); cycles beyond the first are spent in LOAD_STALL.
- MAX_WAIT, 255, memory wait cycles after which mem_timeout is raised (1..255).

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  5  destination register of the load in EX
- mem_req  in  1  MEM stage has an active data-memory access
- mem_ready  in  1  data memory completes the access this cycle
- branch_taken  in  1  branch/jump in EX resolved taken
- pc_write  out  1  PC register enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  load NOP into IF/ID
- idex_bubble  out  1  load NOP into ID/EX
- idex_hold  out  1  ID/EX register holds
- exmem_hold  out  1  EX/MEM register holds
- memwb_bubble  out  1  load NOP into MEM/WB
- mem_timeout  out  1  sticky memory-timeout flag
- perf_stall_cnt  out  32  stall-cycle counter (optional feature)

Behaviour:
- States: RUN, LOAD_STALL, MEM_WAIT. The state register, load counter (4 bit), wait counter (8 bit), mem_timeout and perf counter are clocked.
- Control outputs are combinational from state plus inputs, so they take effect in the same cycle.
- While rst_n=0:
  - state=RUN, counters=0, mem_timeout=0, perf_stall_cnt=0;
  - outputs forced idle: pc_write=1, ifid_write=1, all other control outputs 0.
- Idle values (no condition active): pc_write=1, ifid_write=1, others 0.
- Definitions:
  - freeze = mem_req & ~mem_ready.
  - load_use = ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- Priority in any state: freeze > state-specific > branch_taken > load_use.
- freeze (any state):
  - outputs: pc_write=0, ifid_write=0, idex_hold=1, exmem_hold=1, memwb_bubble=1;
  - branch_taken and load_use are ignored that cycle and are re-evaluated when freeze drops;
  - transitions: RUN->MEM_WAIT; LOAD_STALL stays in LOAD_STALL and its load counter holds.
- RUN, no freeze:
  - branch_taken: ifid_flush=1, idex_bubble=1, pc_write=1; stay RUN.
  - load_use: pc_write=0, ifid_write=0, idex_bubble=1. If LOAD_LAT>1, go to LOAD_STALL with load counter=LOAD_LAT-1; otherwise stay RUN.
- LOAD_STALL, no freeze:
  - outputs: pc_write=0, ifid_write=0, idex_bubble=1; branch_taken is ignored (EX holds a bubble).
  - load counter decrements each cycle; the cycle it reaches 1, the next state is RUN.
- MEM_WAIT:
  - wait counter increments per frozen cycle, saturating at 255.
  - When it equals MAX_WAIT, set mem_timeout. mem_timeout stays 1 until reset and does not alter stalling.
  - The cycle mem_ready=1 (freeze=0): outputs are evaluated by the RUN rules that cycle, next state=RUN, wait counter cleared.
- mem_req deasserting in MEM_WAIT without mem_ready is treated as completion (same as mem_ready=1).
- Reset asserted mid-stall: immediate return to RUN idle outputs; no residual stall after release.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: perf_stall_cnt increments on every clock with rst_n=1 and pc_write=0; saturates at 32'hFFFFFFFF; cleared only by reset.
- Undefined: perf_stall_cnt is constant 0 and no counter register exists.

Test Plan:
- Load-use, LOAD_LAT=1: ex_mem_read=1, ex_rt=8, id_rs=8 for one cycle -> pc_write=0, ifid_write=0, idex_bubble=1 that cycle only; next cycle (ex_mem_read=0) outputs idle. Repeat with ex_rt=0 -> no stall. Repeat with id_rt=8, id_uses_rt=0 -> no stall.
- Load-use, LOAD_LAT=3:
  - Stimulus: ex_rt=5, id_rt=5, id_uses_rt=1, then ex_mem_read=0.
  - Required: exactly 3 consecutive stall cycles, then pc_write=1.
  - Required: perf_stall_cnt=3 with HAZARD_PERF_CNT_EN.
- Branch vs load-use: branch_taken=1 and load_use true together -> ifid_flush=1, idex_bubble=1, pc_write=1, no LOAD_STALL entry.
- Memory wait:
  - Stimulus: mem_req=1, mem_ready=0 for 4 cycles, then mem_ready=1.
  - Required: 4 freeze cycles (exmem_hold=1, memwb_bubble=1); the 5th cycle is idle.
  - Required: a load_use pending during the freeze stalls only after the freeze ends.
- Timeout: MAX_WAIT=10, mem_ready held 0 for 12 cycles -> mem_timeout rises after the 10th wait cycle and stays 1 after mem_ready; cleared only by rst_n=0.
- Reset mid-LOAD_STALL (LOAD_LAT=4, rst_n low in 2nd stall cycle) -> outputs idle immediately; after release with no hazard, pc_write=1 continuously.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for load-use, data-memory wait and taken-branch hazards.
// Optional stall-cycle counter is compiled in with HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rt,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_rt,
   input  logic        mem_req,
   input  logic        mem_ready,
   input  logic        branch_taken,
   output logic        pc_write,
   output logic        ifid_write,
   output logic        ifid_flush,
   output logic        idex_bubble,
   output logic        idex_hold,
   output logic        exmem_hold,
   output logic        memwb_bubble,
   output logic        mem_timeout,
   output logic [31:0] perf_stall_cnt
);

   localparam int unsigned LCNT_W = 4;
   localparam int unsigned WCNT_W = 8;
   localparam int unsigned PERF_W = 32;
   localparam logic [LCNT_W-1:0] LOAD_INIT  = LCNT_W'(LOAD_LAT - 1);
   localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(MAX_WAIT);
   localparam logic [WCNT_W-1:0] WAIT_SAT   = '1;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MEM_WAIT   = 2'd2
   } state_t;

   state_t              state_q, state_nxt;
   logic [LCNT_W-1:0]   lcnt_q, lcnt_nxt;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_nxt;
   logic                timeout_set;
   logic                freeze;
   logic                load_use;

   logic pc_write_r, ifid_write_r, ifid_flush_r, idex_bubble_r;
   logic idex_hold_r, exmem_hold_r, memwb_bubble_r;

   assign freeze   = mem_req & ~mem_ready;
   assign load_use = ex_mem_read & (ex_rt != 5'd0) &
                     ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

   // Next-state and stage controls; freeze overrides everything else.
   always_comb begin
      state_nxt      = state_q;
      lcnt_nxt       = lcnt_q;
      wcnt_nxt       = wcnt_q;
      timeout_set    = 1'b0;
      pc_write_r     = 1'b1;
      ifid_write_r   = 1'b1;
      ifid_flush_r   = 1'b0;
      idex_bubble_r  = 1'b0;
      idex_hold_r    = 1'b0;
      exmem_hold_r   = 1'b0;
      memwb_bubble_r = 1'b0;

      if (freeze) begin
         pc_write_r     = 1'b0;
         ifid_write_r   = 1'b0;
         idex_hold_r    = 1'b1;
         exmem_hold_r   = 1'b1;
         memwb_bubble_r = 1'b1;
         case (state_q)
            LOAD_STALL: begin
               state_nxt = LOAD_STALL;
            end
            default: begin
               // The frozen cycle that leaves RUN is the first counted wait cycle.
               state_nxt   = MEM_WAIT;
               wcnt_nxt    = (wcnt_q == WAIT_SAT) ? wcnt_q : wcnt_q + WCNT_W'(1);
               timeout_set = (wcnt_nxt == WAIT_LIMIT);
            end
         endcase
      end else if (state_q == LOAD_STALL) begin
         pc_write_r    = 1'b0;
         ifid_write_r  = 1'b0;
         idex_bubble_r = 1'b1;
         if (lcnt_q <= LCNT_W'(1)) begin
            state_nxt = RUN;
            lcnt_nxt  = '0;
         end else begin
            lcnt_nxt  = lcnt_q - LCNT_W'(1);
         end
      end else begin
         // RUN, or a memory wait completing this cycle.
         state_nxt = RUN;
         wcnt_nxt  = '0;
         if (branch_taken) begin
            ifid_flush_r  = 1'b1;
            idex_bubble_r = 1'b1;
            pc_write_r    = 1'b1;
         end else if (load_use) begin
            pc_write_r    = 1'b0;
            ifid_write_r  = 1'b0;
            idex_bubble_r = 1'b1;
            if ((state_q == RUN) && (LOAD_LAT > 32'd1)) begin
               state_nxt = LOAD_STALL;
               lcnt_nxt  = LOAD_INIT;
            end
         end
      end
   end

   // State, counters and sticky timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         lcnt_q      <= '0;
         wcnt_q      <= '0;
         mem_timeout <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         lcnt_q      <= lcnt_nxt;
         wcnt_q      <= wcnt_nxt;
         mem_timeout <= mem_timeout | timeout_set;
      end
   end

   // Controls go idle the moment reset is asserted, independent of inputs.
   assign pc_write     = ~rst_n | pc_write_r;
   assign ifid_write   = ~rst_n | ifid_write_r;
   assign ifid_flush   =  rst_n & ifid_flush_r;
   assign idex_bubble  =  rst_n & idex_bubble_r;
   assign idex_hold    =  rst_n & idex_hold_r;
   assign exmem_hold   =  rst_n & exmem_hold_r;
   assign memwb_bubble =  rst_n & memwb_bubble_r;

`ifdef HAZARD_PERF_CNT_EN
   logic [PERF_W-1:0] perf_q;

   // Saturating count of cycles in which the PC is held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_q <= '0;
      end else if (!pc_write && (perf_q != '1)) begin
         perf_q <= perf_q + PERF_W'(1);
      end
   end

   assign perf_stall_cnt = perf_q;
`else
   assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed literal checks plus random stimulus against a cycle model.
module tb_hazard_stall_ctrl;

   localparam int unsigned LOAD_LAT = 3;
   localparam int unsigned MAX_WAIT = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
   logic        id_uses_rt = 1'b0, ex_mem_read = 1'b0;
   logic        mem_req = 1'b0, mem_ready = 1'b0, branch_taken = 1'b0;
   logic        pc_write, ifid_write, ifid_flush, idex_bubble;
   logic        idex_hold, exmem_hold, memwb_bubble, mem_timeout;
   logic [31:0] perf_stall_cnt;

   hazard_stall_ctrl #(.LOAD_LAT(LOAD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken(branch_taken),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .idex_hold(idex_hold), .exmem_hold(exmem_hold),
      .memwb_bubble(memwb_bubble), .mem_timeout(mem_timeout),
      .perf_stall_cnt(perf_stall_cnt)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model state: remaining extra load-stall cycles, frozen cycles in the current wait episode.
   int          ld_left = 0;
   int          waited = 0;
   bit          tmo = 1'b0;
   longint      perf = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] perf_exp(input longint p);
`ifdef HAZARD_PERF_CNT_EN
      return (p > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(p);
`else
      return (p >= 0) ? 32'd0 : 32'd0;
`endif
   endfunction

   // Compare process: outputs vs model every cycle, then advance model for the coming edge.
   always @(negedge clk) begin
      bit         fz, lu;
      logic [6:0] e, a;
      e  = 7'b1100000;
      a  = {pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_hold, memwb_bubble};
      fz = mem_req && !mem_ready;
      lu = ex_mem_read && (ex_rt != 0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
      if (!rst_n) begin
         ld_left = 0; waited = 0; tmo = 1'b0; perf = 0;
         chk("rst_ctrl", 32'(a), 32'(e));
         chk("rst_timeout", 32'(mem_timeout), 32'd0);
         chk("rst_perf", perf_stall_cnt, 32'd0);
      end else begin
         if (fz)                 e = 7'b0000111;
         else if (ld_left > 0)   e = 7'b0001000;
         else if (branch_taken)  e = 7'b1111000;
         else if (lu)            e = 7'b0001000;
         chk("ctrl", 32'(a), 32'(e));
         chk("timeout", 32'(mem_timeout), 32'(tmo));
         chk("perf", perf_stall_cnt, perf_exp(perf));
         if (e[6] == 1'b0) perf++;
         if (fz) begin
            if (ld_left == 0) begin
               if (waited < 255) waited++;
               if (waited == MAX_WAIT) tmo = 1'b1;
            end
         end else if (ld_left > 0) begin
            ld_left--;
         end else begin
            if (!branch_taken && lu && waited == 0) ld_left = LOAD_LAT - 1;
            waited = 0;
         end
      end
   end

   task automatic drive(input bit rn, input bit lr, input logic [4:0] ert, input logic [4:0] rs,
                        input logic [4:0] rt, input bit urt, input bit mq, input bit mr, input bit bt);
      @(posedge clk); #1;
      rst_n = rn; ex_mem_read = lr; ex_rt = ert; id_rs = rs; id_rt = rt;
      id_uses_rt = urt; mem_req = mq; mem_ready = mr; branch_taken = bt;
      #2;
   endtask

   task automatic idle();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      // Reset with a hazard present: controls stay idle.
      drive(0, 1, 8, 8, 0, 0, 1, 0, 1);
      chk("lit_rst_pc", 32'(pc_write), 32'd1);
      chk("lit_rst_hold", 32'({exmem_hold, idex_bubble, ifid_flush}), 32'd0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle();

      // Register zero and unused rt never stall.
      drive(1, 1, 0, 0, 0, 1, 0, 0, 0);
      chk("lit_r0_nostall", 32'(pc_write), 32'd1);
      drive(1, 1, 8, 3, 8, 0, 0, 0, 0);
      chk("lit_rt_unused", 32'(pc_write), 32'd1);

      // Load-use on rt: exactly LOAD_LAT stall cycles.
      drive(1, 1, 5, 0, 5, 1, 0, 0, 0);
      chk("lit_lu_c1", 32'({pc_write, ifid_write, idex_bubble}), 32'b001);
      idle();
      chk("lit_lu_c2", 32'(pc_write), 32'd0);
      idle();
      chk("lit_lu_c3", 32'(pc_write), 32'd0);
      idle();
      chk("lit_lu_done", 32'(pc_write), 32'd1);
`ifdef HAZARD_PERF_CNT_EN
      chk("lit_perf3", perf_stall_cnt, 32'd3);
`else
      chk("lit_perf0", perf_stall_cnt, 32'd0);
`endif

      // Branch beats load-use; no load stall follows.
      drive(1, 1, 8, 8, 0, 0, 0, 0, 1);
      chk("lit_br_lu", 32'({ifid_flush, idex_bubble, pc_write}), 32'b111);
      idle();
      chk("lit_br_after", 32'(pc_write), 32'd1);

      // Four-cycle memory wait, fifth cycle idle.
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
         chk("lit_freeze", 32'({pc_write, exmem_hold, memwb_bubble}), 32'b011);
      end
      drive(1, 0, 0, 0, 0, 0, 1, 1, 0);
      chk("lit_freeze_end", 32'({pc_write, exmem_hold, memwb_bubble}), 32'b100);

      // Load-use pending during freeze only stalls once freeze drops.
      drive(1, 1, 9, 9, 0, 0, 1, 0, 0);
      chk("lit_fz_lu", 32'(idex_bubble), 32'd0);
      drive(1, 1, 9, 9, 0, 0, 1, 1, 0);
      chk("lit_fz_lu_end", 32'({pc_write, idex_bubble, exmem_hold}), 32'b010);
      idle();

      // Timeout after the tenth wait cycle, sticky until reset.
      for (int i = 1; i <= 12; i++) begin
         drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
         if (i == 10) chk("lit_tmo_before", 32'(mem_timeout), 32'd0);
         if (i == 11) chk("lit_tmo_set", 32'(mem_timeout), 32'd1);
      end
      drive(1, 0, 0, 0, 0, 0, 1, 1, 0);
      idle();
      chk("lit_tmo_sticky", 32'(mem_timeout), 32'd1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("lit_tmo_clear", 32'(mem_timeout), 32'd0);

      // Reset during the second load-stall cycle.
      idle();
      drive(1, 1, 7, 7, 0, 0, 0, 0, 0);
      idle();
      chk("lit_ls2", 32'(pc_write), 32'd0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("lit_ls_rst", 32'({pc_write, idex_bubble}), 32'b10);
      for (int i = 0; i < 4; i++) begin
         idle();
         chk("lit_ls_release", 32'(pc_write), 32'd1);
      end

      // Random phase; small register range and biased controls to hit hazards often.
      for (int n = 0; n < 3000; n++) begin
         drive(($urandom_range(99) != 0),
               ($urandom_range(9) < 4),
               5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
               ($urandom_range(1) == 1),
               ($urandom_range(9) < 3),
               ($urandom_range(9) < 4),
               ($urandom_range(9) < 2));
      end
      idle();
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
